interp_window_buffer: RTL and testbench
=======================================

// Module: interp_window_buffer
// PURPOSE
//  Parametrised sliding row-window buffer for the sub-pixel interpolation datapath.
//  - Accepts one row of ROW_PIX reference pixels per valid/ready handshake.
//  - Holds the most recent DEPTH rows and presents them as one flat window, optionally
//    transposed to column-major, for the 8-tap filter array.
//  - Adds back-pressure, sliding-window reuse, fill tracking and a synchronous flush.
// PARAMETERS
//  PIX_W     8   bits per pixel
//  ROW_PIX   8   pixels per input row
//  DEPTH     15  rows held (ROWS_OUT + TAPS - 1); must be >= 2
//  TRANSPOSE 1   1: window column-major; 0: row-major
// PORTS
//  clock     in   1                    rising-edge clock
//  reset_L   in   1                    asynchronous, active-low reset
//  clear     in   1                    synchronous flush; priority over everything except reset
//  in_valid  in   1                    in_row holds a valid row
//  in_ready  out  1                    buffer accepts a row this cycle
//  in_row    in   ROW_PIX*PIX_W        pixel j at [j*PIX_W +: PIX_W]
//  win_valid out  1                    win holds a complete, not-yet-consumed window
//  win_ready in   1                    downstream consumes the window this cycle
//  win       out  DEPTH*ROW_PIX*PIX_W  window (layout below)
//  fill_cnt  out  $clog2(DEPTH+1)      rows held, saturates at DEPTH
// BEHAVIOUR
//  - Clocking and reset
//    - All state updates on posedge clock.
//    - reset_L low: asynchronously clears all rows and fill_cnt to 0, state FILL.
//    - Reset values: win=0, win_valid=0, in_ready=1, fill_cnt=0.
//  - Handshakes
//    - accept  = in_valid & in_ready & ~clear.
//    - consume = win_valid & win_ready & ~clear.
//  - Shift
//    - On accept: row[i] <= row[i+1] for i < DEPTH-1; row[DEPTH-1] <= in_row.
//    - row[0] is the oldest row.
//  - Layout (win is decoded combinationally from the row registers, so it changes on
//    the same edge as the rows):
//    - TRANSPOSE=1: pixel j of row i at win[(j*DEPTH+i)*PIX_W +: PIX_W].
//    - TRANSPOSE=0: pixel j of row i at win[(i*ROW_PIX+j)*PIX_W +: PIX_W].
//  - fill_cnt: +1 on accept while fill_cnt < DEPTH; holds at DEPTH.
//  - States
//    - FILL: in_ready=1, win_valid=0.
//      - On accept, go to VALID if fill_cnt == DEPTH-1, otherwise stay in FILL.
//    - VALID: win_valid=1, in_ready=win_ready (a new row only slides in once the current
//      window is taken).
//      - accept & consume: shift, stay in VALID; the new window is presented next cycle.
//      - consume & ~in_valid: go to USED.
//      - no consume: hold; win stays bit-stable.
//    - USED: win_valid=0, in_ready=1.
//      - On accept: shift, go to VALID. No window is ever presented twice.
//  - clear
//    - Forces in_ready=0 the same cycle; no handshake completes.
//    - Next edge: rows=0, fill_cnt=0, state FILL.
//  - Latency
//    - A row accepted at edge k is visible in win after edge k.
//    - win_valid rises after the edge completing the DEPTH-th accept since reset/clear.
//  - Steady sliding throughput: one window per cycle with in_valid=win_ready=1.
// TESTING (PIX_W=8, ROW_PIX=8, DEPTH=15, TRANSPOSE=1; row n pixel j = n*16+j)
//  1 Reset, push rows 0..14 back-to-back -> win_valid=0 until after the 15th accept, then 1;
//    fill_cnt=15; win[7:0]=8'h00, win[15:8]=8'h10, win[127:120]=8'h01.
//  2 Full, win_ready=0, in_valid=1 for 5 cycles -> in_ready=0, win and fill_cnt unchanged.
//  3 Full, in_valid=win_ready=1, push row 15 -> win_valid stays 1; win[7:0]=8'h10,
//    win[119:112]=8'hF0; fill_cnt stays 15.
//  4 Full, one-cycle win_ready pulse with in_valid=0 -> win_valid=0 next cycle, in_ready=1;
//    next accept -> win_valid=1.
//  5 clear with in_valid=1 at fill_cnt=7 -> in_ready=0 that cycle; next cycle fill_cnt=0,
//    win=0, the row is not stored.
//  6 reset_L low mid-VALID, asynchronously between edges -> win=0, win_valid=0,
//    fill_cnt=0, in_ready=1 immediately.

Source files
------------

// File: rtl/interp_window_buffer.sv
// ---------------------------------------------------------------------------
// interp_window_buffer
//   Sliding row-window buffer feeding the 8-tap sub-pixel filter array.
//   Accepts one row of ROW_PIX pixels per valid/ready handshake, keeps the
//   most recent DEPTH rows and presents them as one flat window (optionally
//   column-major). Each full window is presented exactly once; a new row only
//   slides in once the current window has been taken downstream.
//
// Ports
//   clock      in   rising-edge clock
//   reset_L    in   asynchronous active-low reset
//   clear      in   synchronous flush, wins over every handshake
//   in_valid   in   in_row carries a valid row
//   in_ready   out  a row is accepted this cycle when in_valid is high
//   in_row     in   pixel j at [j*PIX_W +: PIX_W]
//   win_valid  out  win holds a complete, not-yet-consumed window
//   win_ready  in   downstream takes the window this cycle
//   win        out  DEPTH rows of ROW_PIX pixels (row- or column-major)
//   fill_cnt   out  rows held, saturating at DEPTH
// ---------------------------------------------------------------------------
module interp_window_buffer #(
  parameter int PIX_W     = 8,
  parameter int ROW_PIX   = 8,
  parameter int DEPTH     = 15,
  parameter int TRANSPOSE = 1,
  localparam int ROW_W    = ROW_PIX * PIX_W,
  localparam int WIN_W    = DEPTH * ROW_W,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_row,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [WIN_W-1:0] win,
  output logic [CNT_W-1:0] fill_cnt
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_VALID = 2'd1,
    ST_USED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [ROW_W-1:0] rows_q    [DEPTH];
  logic [ROW_W-1:0] shift_src [DEPTH];

  logic accept;
  logic consume;

  // Handshakes never complete while a flush is requested.
  assign accept  = in_valid & in_ready & ~clear;
  assign consume = win_valid & win_ready & ~clear;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_FILL;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    if (clear) begin
      state_d    = ST_FILL;
      fill_cnt_d = '0;
    end else begin
      if (accept && (fill_cnt_q < CNT_W'(DEPTH)))
        fill_cnt_d = fill_cnt_q + 1'b1;
      unique case (state_q)
        ST_FILL: begin
          if (accept && (fill_cnt_q == CNT_W'(DEPTH - 1)))
            state_d = ST_VALID;
        end
        ST_VALID: begin
          // In VALID in_ready follows win_ready, so an accept always
          // coincides with a consume; a consume alone leaves the window used.
          if (consume && !accept)
            state_d = ST_USED;
        end
        ST_USED: begin
          if (accept)
            state_d = ST_VALID;
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    win_valid = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        in_ready = ~clear;
      end
      ST_VALID: begin
        win_valid = 1'b1;
        in_ready  = win_ready & ~clear;
      end
      ST_USED: begin
        in_ready = ~clear;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign fill_cnt = fill_cnt_q;

  // -------------------------------------------------------------------------
  // Row shift register: row 0 is the oldest, the newest enters at DEPTH-1.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
      if (gi == DEPTH - 1) begin : g_top
        assign shift_src[gi] = in_row;
      end else begin : g_mid
        assign shift_src[gi] = rows_q[gi+1];
      end

      always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L)
          rows_q[gi] <= '0;
        else if (clear)
          rows_q[gi] <= '0;
        else if (accept)
          rows_q[gi] <= shift_src[gi];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Window decode: pure wiring from the row registers.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_win_row
      for (genvar gj = 0; gj < ROW_PIX; gj++) begin : g_win_pix
        if (TRANSPOSE != 0) begin : g_col_major
          assign win[(gj*DEPTH + gi)*PIX_W +: PIX_W] = rows_q[gi][gj*PIX_W +: PIX_W];
        end else begin : g_row_major
          assign win[(gi*ROW_PIX + gj)*PIX_W +: PIX_W] = rows_q[gi][gj*PIX_W +: PIX_W];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_interp_window_buffer.sv
module tb_interp_window_buffer;

  localparam int PIX_W     = 8;
  localparam int ROW_PIX   = 8;
  localparam int DEPTH     = 15;
  localparam int TRANSPOSE = 1;
  localparam int ROW_W     = ROW_PIX * PIX_W;
  localparam int WIN_W     = DEPTH * ROW_W;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset_L;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_row;
  logic             win_valid;
  logic             win_ready;
  logic [WIN_W-1:0] win;
  logic [CNT_W-1:0] fill_cnt;

  interp_window_buffer #(
    .PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .DEPTH(DEPTH), .TRANSPOSE(TRANSPOSE)
  ) dut (
    .clock(clock), .reset_L(reset_L), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .win_valid(win_valid), .win_ready(win_ready), .win(win),
    .fill_cnt(fill_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // A list of the last DEPTH rows (index 0 oldest), a count of rows seen
  // (capped) and whether the current full window has not yet been handed out.
  logic [ROW_W-1:0] m_rows [DEPTH];
  int               m_cnt;
  bit               m_fresh;

  function automatic bit m_win_valid();
    return (m_cnt == DEPTH) && m_fresh;
  endfunction

  function automatic bit m_in_ready();
    if (clear) return 1'b0;
    return !m_win_valid() || win_ready;
  endfunction

  function automatic logic [WIN_W-1:0] m_win();
    logic [WIN_W-1:0] w;
    w = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < ROW_PIX; j++)
        if (TRANSPOSE != 0)
          w[(j*DEPTH + i)*PIX_W +: PIX_W] = m_rows[i][j*PIX_W +: PIX_W];
        else
          w[(i*ROW_PIX + j)*PIX_W +: PIX_W] = m_rows[i][j*PIX_W +: PIX_W];
    return w;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_rows[i] = '0;
    m_cnt   = 0;
    m_fresh = 1'b0;
  endtask

  // One clock edge of the model, using the inputs present before the edge.
  task automatic m_step();
    bit acc, cons;
    if (clear) begin
      m_reset();
    end else begin
      acc  = in_valid && m_in_ready();
      cons = m_win_valid() && win_ready;
      if (acc) begin
        for (int i = 0; i < DEPTH - 1; i++) m_rows[i] = m_rows[i+1];
        m_rows[DEPTH-1] = in_row;
        if (m_cnt < DEPTH) m_cnt++;
        m_fresh = (m_cnt == DEPTH);
        $display("t=%0t accept row=%h cnt=%0d", $time, in_row, m_cnt);
      end else if (cons) begin
        m_fresh = 1'b0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [WIN_W-1:0] act,
                     input logic [WIN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    chk("in_ready",  WIN_W'(in_ready),  WIN_W'(m_in_ready()));
    chk("win_valid", WIN_W'(win_valid), WIN_W'(m_win_valid()));
    chk("fill_cnt",  WIN_W'(fill_cnt),  WIN_W'(m_cnt));
    chk("win",       win,               m_win());
  endtask

  // Inputs are set one time unit after a rising edge; outputs are checked at
  // the falling edge; the model advances on the rising edge.
  task automatic cycle();
    @(negedge clock);
    compare();
    @(posedge clock);
    m_step();
    #1;
  endtask

  task automatic drive(input bit v, input logic [ROW_W-1:0] r,
                       input bit wr, input bit clr);
    in_valid  = v;
    in_row    = r;
    win_ready = wr;
    clear     = clr;
    cycle();
  endtask

  function automatic logic [ROW_W-1:0] pat_row(input int n);
    logic [ROW_W-1:0] r;
    for (int j = 0; j < ROW_PIX; j++) r[j*PIX_W +: PIX_W] = PIX_W'(n*16 + j);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] rnd_row();
    logic [ROW_W-1:0] r;
    for (int j = 0; j < ROW_PIX; j++) r[j*PIX_W +: PIX_W] = PIX_W'($urandom);
    return r;
  endfunction

  logic [WIN_W-1:0] win_snap;

  initial begin
    reset_L = 1'b0; clear = 1'b0; in_valid = 1'b0; win_ready = 1'b0; in_row = '0;
    m_reset();
    #2;
    compare();
    chk("rst_in_ready", WIN_W'(in_ready), WIN_W'(1));
    #10 reset_L = 1'b1;
    @(posedge clock); #1;

    // 1: fill with rows 0..14 back-to-back
    for (int n = 0; n < DEPTH; n++) drive(1'b1, pat_row(n), 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clock);
    chk("t1_win_valid", WIN_W'(win_valid), WIN_W'(1));
    chk("t1_fill_cnt",  WIN_W'(fill_cnt),  WIN_W'(15));
    chk("t1_px0",   WIN_W'(win[7:0]),     WIN_W'(8'h00));
    chk("t1_px1",   WIN_W'(win[15:8]),    WIN_W'(8'h10));
    chk("t1_px15",  WIN_W'(win[127:120]), WIN_W'(8'h01));
    chk("t1_model_cnt", WIN_W'(m_cnt), WIN_W'(15));
    @(posedge clock); #1;

    // 2: full and stalled downstream
    win_snap = win;
    for (int k = 0; k < 5; k++) drive(1'b1, pat_row(99), 1'b0, 1'b0);
    @(negedge clock);
    chk("t2_win_hold", win, win_snap);
    chk("t2_in_ready", WIN_W'(in_ready), WIN_W'(0));
    chk("t2_fill_cnt", WIN_W'(fill_cnt), WIN_W'(15));
    @(posedge clock); #1;

    // 3: slide in row 15
    drive(1'b1, pat_row(15), 1'b1, 1'b0);
    in_valid = 1'b0; win_ready = 1'b0;
    @(negedge clock);
    chk("t3_win_valid", WIN_W'(win_valid),     WIN_W'(1));
    chk("t3_px0",       WIN_W'(win[7:0]),      WIN_W'(8'h10));
    chk("t3_px14",      WIN_W'(win[119:112]),  WIN_W'(8'hF0));
    chk("t3_fill_cnt",  WIN_W'(fill_cnt),      WIN_W'(15));
    @(posedge clock); #1;

    // 4: consume without a new row, then refill one row
    drive(1'b0, '0, 1'b1, 1'b0);
    win_ready = 1'b0;
    @(negedge clock);
    chk("t4_used_valid", WIN_W'(win_valid), WIN_W'(0));
    chk("t4_used_ready", WIN_W'(in_ready),  WIN_W'(1));
    @(posedge clock); #1;
    drive(1'b1, pat_row(16), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t4_revalid", WIN_W'(win_valid), WIN_W'(1));

    // 5: flush, refill to 7, flush with a row offered
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int n = 0; n < 7; n++) drive(1'b1, pat_row(n + 40), 1'b0, 1'b0);
    in_valid = 1'b1; in_row = pat_row(77); clear = 1'b1;
    @(negedge clock);
    chk("t5_ready_clr", WIN_W'(in_ready), WIN_W'(0));
    chk("t5_cnt_before", WIN_W'(fill_cnt), WIN_W'(7));
    @(posedge clock); m_step(); #1;
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t5_cnt_after", WIN_W'(fill_cnt), WIN_W'(0));
    chk("t5_win_zero",  win,              WIN_W'(0));

    // 6: asynchronous reset in the middle of VALID
    for (int n = 0; n < DEPTH; n++) drive(1'b1, rnd_row(), 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("t6_pre_valid", WIN_W'(win_valid), WIN_W'(1));
    #2 reset_L = 1'b0;
    #1;
    chk("t6_win",       win,               WIN_W'(0));
    chk("t6_win_valid", WIN_W'(win_valid), WIN_W'(0));
    chk("t6_fill_cnt",  WIN_W'(fill_cnt),  WIN_W'(0));
    chk("t6_in_ready",  WIN_W'(in_ready),  WIN_W'(1));
    m_reset();
    #3 reset_L = 1'b1;
    @(posedge clock); #1;

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, rnd_row(),
            $urandom_range(0, 4) < 3, $urandom_range(0, 99) < 2);
    end
    // Sustained sliding: one window per cycle
    for (int c = 0; c < 40; c++) drive(1'b1, rnd_row(), 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
